clock_div_sync: RTL and testbench

CLOCK_DIV_SYNC -- requirements
Module: clock_div_sync

---
 rtl/clock_div_sync_pkg.sv | 12 +
 rtl/sync_2ff.sv | 21 ++
 rtl/clock_div_sync.sv | 57 +++++
 tb/tb_clock_div_sync.sv | 106 ++++++++++
 4 files changed

// File: rtl/clock_div_sync_pkg.sv
// Shared helpers for the clock divider / synchronizer slice.
// Only the counter sizing rule lives here; the parameters stay on the module.
package clock_div_sync_pkg;

  // Counter width that can hold half-1 without relying on wrap-around.
  function automatic int cnt_width(input int half);
    int w;
    w = $clog2(half);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic async_signal,
  output logic synchronized_signal
);

  logic stage1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage1_q            <= 1'b0;
      synchronized_signal <= 1'b0;
    end else begin
      stage1_q            <= async_signal;
      synchronized_signal <= stage1_q;
    end
  end

endmodule

// File: rtl/clock_div_sync.sv
// 50% duty clock divider with a rise tick, plus WIDTH independent
// two-flop synchronizers for slow level inputs such as buttons.
module clock_div_sync
  import clock_div_sync_pkg::*;
#(
  parameter int HALF_OF_CLK_CYCLE_VALUE = 25000000,
  parameter int WIDTH                   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic             slow_clk,
  output logic             slow_tick
);

  localparam int            CNT_W = cnt_width(HALF_OF_CLK_CYCLE_VALUE);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(HALF_OF_CLK_CYCLE_VALUE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             slow_q, slow_d;
  logic             tick_q, tick_d;
  logic             wrap;

  // Explicit compare-and-clear keeps the counter bounded for any half value.
  always_comb begin
    wrap   = (cnt_q == TERM);
    cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
    slow_d = slow_q ^ wrap;
    tick_d = wrap & ~slow_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      slow_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      slow_q <= slow_d;
      tick_q <= tick_d;
    end
  end

  assign slow_clk  = slow_q;
  assign slow_tick = tick_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_sync
    sync_2ff u_sync (
      .clk                 (clk),
      .reset               (reset),
      .async_signal        (async_in[i]),
      .synchronized_signal (sync_out[i])
    );
  end

endmodule

// File: tb/tb_clock_div_sync.sv
// Directed bench: divider with half=4 and half=1, synchronizer latency,
// glitch propagation and asynchronous mid-period reset.
module tb_clock_div_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] async_in = 4'b0000;
  logic [3:0] sync_out, sync_out1;
  logic       slow_clk, slow_tick, slow_clk1, slow_tick1;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  clock_div_sync #(.HALF_OF_CLK_CYCLE_VALUE(4), .WIDTH(4)) dut (
    .clk(clk), .reset(rst), .async_in(async_in), .sync_out(sync_out),
    .slow_clk(slow_clk), .slow_tick(slow_tick)
  );

  clock_div_sync #(.HALF_OF_CLK_CYCLE_VALUE(1), .WIDTH(4)) dut1 (
    .clk(clk), .reset(rst), .async_in(async_in), .sync_out(sync_out1),
    .slow_clk(slow_clk1), .slow_tick(slow_tick1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #12;
    check("rst_slow", 32'(slow_clk), 0);
    check("rst_tick", 32'(slow_tick), 0);
    check("rst_sync", 32'(sync_out), 0);
    check("rst_slow1", 32'(slow_clk1), 0);

    @(negedge clk);
    rst = 1'b0;
    // half=4: rise at edges 4 and 12, fall at 8; half=1: toggles every edge
    for (int e = 1; e <= 16; e++) begin
      edge1();
      check($sformatf("h4_slow_e%0d", e), 32'(slow_clk), 32'(((e / 4) % 2) == 1));
      check($sformatf("h4_tick_e%0d", e), 32'(slow_tick), 32'((e % 8) == 4));
      check($sformatf("h1_slow_e%0d", e), 32'(slow_clk1), 32'((e % 2) == 1));
      check($sformatf("h1_tick_e%0d", e), 32'(slow_tick1), 32'((e % 2) == 1));
    end

    // synchronizer latency: 0000 -> 0101
    @(negedge clk);
    async_in = 4'b0101;
    edge1();
    check("sync_lat_e1", 32'(sync_out), 32'h0);
    edge1();
    check("sync_lat_e2", 32'(sync_out), 32'h5);

    // one-cycle glitch on bit 3
    @(negedge clk);
    async_in = 4'b1101;
    @(negedge clk);
    async_in = 4'b0101;
    #4;
    check("glitch_a", 32'(sync_out), 32'h5);
    edge1();
    check("glitch_b", 32'(sync_out), 32'hd);
    edge1();
    check("glitch_c", 32'(sync_out), 32'h5);

    // fresh start, then reset mid high phase at counter=2
    @(negedge clk);
    rst = 1'b1;
    async_in = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) edge1();
    check("pre_rst_slow", 32'(slow_clk), 1);
    check("pre_rst_sync", 32'(sync_out), 32'hf);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_slow", 32'(slow_clk), 0);
    check("async_rst_sync", 32'(sync_out), 0);
    check("async_rst_tick", 32'(slow_tick), 0);

    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      edge1();
      check($sformatf("post_rst_slow_e%0d", e), 32'(slow_clk), 32'(e == 4));
      check($sformatf("post_rst_tick_e%0d", e), 32'(slow_tick), 32'(e == 4));
      check($sformatf("post_rst_sync_e%0d", e), 32'(sync_out), (e >= 2) ? 32'hf : 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
